satatb_hostshake: RTL
=====================

// Module: satatb_hostshake
// PURPOSE
//  Host-side SATA OOB (COM) handshake sequencer, one i_txclk per serial bit.
//  Sends COMRESET bursts and waits for the device's COMINIT.
//  Then sends COMWAKE bursts and waits for the device's COMWAKE.
//  Finally passes i_tx through to the line and raises o_link_up.
//  Sits between the link layer and the serial line, driven by an external COM detector.
// PARAMETERS
//  NUM_BURSTS     6      bursts per COMRESET and per COMWAKE
//  COMRESET_IDLES 480    idle (zero) cycles after each COMRESET burst (~320ns)
//  COMWAKE_IDLES  160    idle cycles after each COMWAKE burst (~106.7ns)
//  TIMEOUT        16384  cycles to wait for a device response before retry
// PORTS
//  i_txclk    in   1  bit clock; all logic on posedge
//  i_reset    in   1  synchronous, active-high reset
//  i_start    in   1  request link init; sampled in IDLE and ACTIVE
//  i_cominit  in   1  COMINIT detected (level, pre-synchronized to i_txclk)
//  i_comwake  in   1  COMWAKE detected (level, pre-synchronized to i_txclk)
//  i_tx       in   1  serial data bit, forwarded only in ACTIVE
//  o_tx_p     out  1  line +; registered r_tx
//  o_tx_n     out  1  line -; always !o_tx_p
//  o_link_up  out  1  high only in ACTIVE
//  o_retries  out  4  COMRESET retry count, saturates at 15
//  o_state    out  3  current FSM state (debug)
// BEHAVIOUR
//  Reset: state=IDLE, r_tx=0 (o_tx_p=0, o_tx_n=1), o_link_up=0, o_retries=0.
//   All counters are cleared. Reset overrides every other input on the same edge.
//  Burst definition:
//   - D24_3 = 10'b1100110011; COM_SEQ = {D24_3,~D24_3,D24_3,~D24_3} (40 bits).
//   - Each burst is COM_SEQ sent 4 times, MSB first: 160 cycles. The first bit is 1.
//   - Each burst is followed by IDLES cycles of r_tx=0.
//   - The final burst of a group has no trailing idle. The next state is entered on the
//     cycle after its last bit.
//  States:
//   IDLE(0):
//    - r_tx=0.
//    - i_start -> SEND_RESET.
//   SEND_RESET(1):
//    - Send NUM_BURSTS bursts with COMRESET_IDLES gaps, then go to WAIT_INIT.
//    - i_cominit is ignored in this state.
//   WAIT_INIT(2):
//    - r_tx=0; the timer counts up.
//    - Wait for i_cominit high, then for i_cominit low; then go to SEND_WAKE.
//    - Timer reaching TIMEOUT-1 with no COMINIT: go to SEND_RESET and increment
//      o_retries (saturating).
//   SEND_WAKE(3):
//    - Send NUM_BURSTS bursts with COMWAKE_IDLES gaps, then go to WAIT_WAKE.
//   WAIT_WAKE(4):
//    - r_tx=0; the timer counts up.
//    - i_comwake high -> WAIT_RELEASE.
//    - Timeout -> SEND_RESET and retry++.
//   WAIT_RELEASE(5):
//    - r_tx=0.
//    - i_comwake low -> ACTIVE.
//    - Timeout -> SEND_RESET and retry++.
//   ACTIVE(6):
//    - r_tx<=i_tx (1-cycle latency); o_link_up=1.
//    - i_cominit or i_start -> SEND_RESET; o_link_up drops the next cycle.
//  Timing and counters:
//   - Entering any SEND_* state reloads the bit, subburst, burst and idle counters.
//   - The first burst bit appears on o_tx_p two edges after the triggering input is
//     sampled: one edge for the state change, one for the r_tx register.
//   - The timer is cleared on every state change.
//   - o_retries clears only on i_reset.
//   - Simultaneous timeout and detector edge: the detector event wins.
//  Widths:
//   - Idle counter width = $clog2(max(COMRESET_IDLES,COMWAKE_IDLES)+1).
//   - Timer width = $clog2(TIMEOUT+1).
// TESTING
//  1. i_start; loopback device model answers COMINIT and COMWAKE:
//     - o_tx_p shows 6x160-bit bursts with 480 zero cycles between them.
//     - Then 6x160-bit bursts with 160 zero cycles between them.
//     - o_link_up rises 1 cycle after i_comwake falls.
//  2. i_start, no COMINIT:
//     - COMRESET restarts exactly TIMEOUT cycles after WAIT_INIT entry; o_retries=1.
//     - After 16 more timeouts, o_retries=15 (saturated).
//  3. In ACTIVE, drive i_tx=1,0,1,1:
//     - o_tx_p matches 1 cycle later; o_tx_n is always its inverse.
//  4. i_reset asserted mid-COMWAKE burst:
//     - Next cycle: o_tx_p=0, o_state=0, o_link_up=0, o_retries=0.
//  5. i_cominit pulse in ACTIVE:
//     - o_link_up=0 next cycle; the first COMRESET bit (1) follows the cycle after.
//  6. i_cominit held high throughout SEND_RESET:
//     - No early exit.
//     - WAIT_INIT advances to SEND_WAKE only after i_cominit falls.

Source files
------------

// File: rtl/satatb_hostshake.sv
// Host-side SATA OOB sequencer: COMRESET bursts, wait for COMINIT, COMWAKE bursts,
// wait for the device COMWAKE, then forward i_tx to the line with o_link_up high.
module satatb_hostshake #(
  parameter int NUM_BURSTS     = 6,
  parameter int COMRESET_IDLES = 480,
  parameter int COMWAKE_IDLES  = 160,
  parameter int TIMEOUT        = 16384
) (
  input  logic       i_txclk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_cominit,
  input  logic       i_comwake,
  input  logic       i_tx,
  output logic       o_tx_p,
  output logic       o_tx_n,
  output logic       o_link_up,
  output logic [3:0] o_retries,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SEND_RESET   = 3'd1,
    WAIT_INIT    = 3'd2,
    SEND_WAKE    = 3'd3,
    WAIT_WAKE    = 3'd4,
    WAIT_RELEASE = 3'd5,
    ACTIVE       = 3'd6
  } state_e;

  localparam int MAX_IDLES = (COMRESET_IDLES > COMWAKE_IDLES) ? COMRESET_IDLES : COMWAKE_IDLES;
  localparam int IDLE_W    = (MAX_IDLES > 0) ? $clog2(MAX_IDLES + 1) : 1;
  localparam int TIMER_W   = $clog2(TIMEOUT + 1);
  localparam int BURST_W   = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  localparam logic [9:0]         D24_3      = 10'b1100110011;
  localparam logic [39:0]        COM_SEQ    = {D24_3, ~D24_3, D24_3, ~D24_3};
  localparam logic [IDLE_W-1:0]  RESET_GAP  = IDLE_W'(COMRESET_IDLES);
  localparam logic [IDLE_W-1:0]  WAKE_GAP   = IDLE_W'(COMWAKE_IDLES);
  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [5:0]           bitCnt_q, bitCnt_d;
  logic [1:0]           subCnt_q, subCnt_d;
  logic [BURST_W-1:0]   burstCnt_q, burstCnt_d;
  logic [IDLE_W-1:0]    idleCnt_q, idleCnt_d;
  logic                 inGap_q, inGap_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 seenInit_q, seenInit_d;
  logic [3:0]           retries_q, retries_d;

  logic [IDLE_W-1:0]    gapLen;
  logic [5:0]           seqIdx;
  logic                 timeoutHit;
  logic [3:0]           retriesInc;

  assign gapLen     = (state_q == SEND_RESET) ? RESET_GAP : WAKE_GAP;
  assign seqIdx     = 6'd39 - bitCnt_q;
  assign timeoutHit = (timer_q == TIMER_LAST);
  assign retriesInc = (retries_q == 4'hF) ? 4'hF : retries_q + 4'd1;

  always_ff @(posedge i_txclk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b0;
      bitCnt_q   <= '0;
      subCnt_q   <= '0;
      burstCnt_q <= '0;
      idleCnt_q  <= '0;
      inGap_q    <= 1'b0;
      timer_q    <= '0;
      seenInit_q <= 1'b0;
      retries_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      bitCnt_q   <= bitCnt_d;
      subCnt_q   <= subCnt_d;
      burstCnt_q <= burstCnt_d;
      idleCnt_q  <= idleCnt_d;
      inGap_q    <= inGap_d;
      timer_q    <= timer_d;
      seenInit_q <= seenInit_d;
      retries_q  <= retries_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = 1'b0;
    bitCnt_d   = bitCnt_q;
    subCnt_d   = subCnt_q;
    burstCnt_d = burstCnt_q;
    idleCnt_d  = idleCnt_q;
    inGap_d    = inGap_q;
    timer_d    = timer_q;
    seenInit_d = seenInit_q;
    retries_d  = retries_q;

    case (state_q)
      IDLE: begin
        if (i_start) state_d = SEND_RESET;
      end

      SEND_RESET, SEND_WAKE: begin
        if (!inGap_q) begin
          tx_d = COM_SEQ[seqIdx];
          if (bitCnt_q == 6'd39) begin
            bitCnt_d = '0;
            subCnt_d = subCnt_q + 2'd1;
            // Last bit of the last burst hands over directly, with no trailing gap.
            if (subCnt_q == 2'd3) begin
              if (burstCnt_q == LAST_BURST) begin
                state_d = (state_q == SEND_RESET) ? WAIT_INIT : WAIT_WAKE;
              end else if (gapLen == '0) begin
                burstCnt_d = burstCnt_q + 1'b1;
              end else begin
                inGap_d   = 1'b1;
                idleCnt_d = '0;
              end
            end
          end else begin
            bitCnt_d = bitCnt_q + 6'd1;
          end
        end else begin
          if (idleCnt_q == gapLen - 1'b1) begin
            inGap_d    = 1'b0;
            idleCnt_d  = '0;
            burstCnt_d = burstCnt_q + 1'b1;
          end else begin
            idleCnt_d = idleCnt_q + 1'b1;
          end
        end
      end

      WAIT_INIT: begin
        if (!timeoutHit) timer_d = timer_q + 1'b1;
        // Once COMINIT has been seen only its release matters, never the timer.
        if (i_cominit) begin
          seenInit_d = 1'b1;
        end else if (seenInit_q) begin
          state_d = SEND_WAKE;
        end else if (timeoutHit) begin
          state_d   = SEND_RESET;
          retries_d = retriesInc;
        end
      end

      WAIT_WAKE: begin
        if (!timeoutHit) timer_d = timer_q + 1'b1;
        if (i_comwake) begin
          state_d = WAIT_RELEASE;
        end else if (timeoutHit) begin
          state_d   = SEND_RESET;
          retries_d = retriesInc;
        end
      end

      WAIT_RELEASE: begin
        if (!timeoutHit) timer_d = timer_q + 1'b1;
        if (!i_comwake) begin
          state_d = ACTIVE;
        end else if (timeoutHit) begin
          state_d   = SEND_RESET;
          retries_d = retriesInc;
        end
      end

      ACTIVE: begin
        tx_d = i_tx;
        if (i_cominit || i_start) state_d = SEND_RESET;
      end

      default: state_d = IDLE;
    endcase

    // Any state change restarts burst generation and the response timer.
    if (state_d != state_q) begin
      bitCnt_d   = '0;
      subCnt_d   = '0;
      burstCnt_d = '0;
      idleCnt_d  = '0;
      inGap_d    = 1'b0;
      timer_d    = '0;
      seenInit_d = 1'b0;
    end
  end

  assign o_tx_p    = tx_q;
  assign o_tx_n    = ~tx_q;
  assign o_link_up = (state_q == ACTIVE);
  assign o_retries = retries_q;
  assign o_state   = state_q;

endmodule
